// File: rtl/multi_channel_pipe_reg.sv
// Purpose : CHANNELS x WIDTH lanes carried through p_depth valid/ready register stages, with bubble collapse and flush.
// Latency : p_depth-1 cycles from acceptance to out_valid when unstalled; one beat per cycle.
// Backpressure: out_ready=0 stalls the full stages; empty stages keep accepting. Optional PIPE_OCCUPANCY_CNT_EN adds occupancy.
module multi_channel_pipe_reg #(
   parameter int                    p_width         = 8,
   parameter int                    p_channels      = 3,
   parameter int                    p_depth         = 2,
   parameter logic [p_channels-1:0] p_rst_ones_mask = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [p_channels*p_width-1:0] in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [p_channels*p_width-1:0] out_data
`ifdef PIPE_OCCUPANCY_CNT_EN
   ,
   output logic [$clog2(p_depth+1)-1:0]  occupancy
`endif
);

   localparam int lp_dw = p_channels * p_width;

   // Channels whose mask bit is set reset to all-ones, the rest to all-zeros.
   function automatic logic [lp_dw-1:0] f_rst_pat();
      logic [lp_dw-1:0] v_pat;
      v_pat = '0;
      for (int c = 0; c < p_channels; c++) begin
         if (p_rst_ones_mask[c]) begin
            v_pat[c*p_width +: p_width] = '1;
         end
      end
      return v_pat;
   endfunction

   localparam logic [lp_dw-1:0] lp_rst_pat = f_rst_pat();

   logic [p_depth-1:0] r_vld;
   logic [lp_dw-1:0]   r_data [p_depth];
   logic [p_depth-1:0] w_rdy;
   logic [p_depth-1:0] w_src_vld;
   logic [lp_dw-1:0]   w_src_dat [p_depth];

   // Ready ripples back from the output: a stage can load if it is empty or its contents move on.
   always_comb begin
      logic v_acc;
      w_rdy = '0;
      v_acc = !r_vld[p_depth-1] | out_ready;
      w_rdy[p_depth-1] = v_acc;
      for (int s = p_depth - 2; s >= 0; s--) begin
         v_acc    = !r_vld[s] | v_acc;
         w_rdy[s] = v_acc;
      end
   end

   // Source of each stage: the input port for stage 0, the previous stage otherwise.
   always_comb begin
      w_src_vld = '0;
      for (int s = 0; s < p_depth; s++) begin
         w_src_dat[s] = '0;
      end
      w_src_vld[0] = in_valid;
      w_src_dat[0] = in_data;
      for (int s = 1; s < p_depth; s++) begin
         w_src_vld[s] = r_vld[s-1];
         w_src_dat[s] = r_data[s-1];
      end
   end

   // Stage registers: reset beats flush beats any handshake; data only moves with a valid beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         for (int s = 0; s < p_depth; s++) begin
            r_data[s] <= lp_rst_pat;
         end
      end else if (flush) begin
         r_vld <= '0;
      end else begin
         for (int s = 0; s < p_depth; s++) begin
            if (w_rdy[s]) begin
               r_vld[s] <= w_src_vld[s];
               if (w_src_vld[s]) begin
                  r_data[s] <= w_src_dat[s];
               end
            end
         end
      end
   end

   assign in_ready  = w_rdy[0];
   assign out_valid = r_vld[p_depth-1];
   assign out_data  = r_data[p_depth-1];

`ifdef PIPE_OCCUPANCY_CNT_EN
   localparam int lp_ow = $clog2(p_depth + 1);

   logic [lp_ow-1:0] r_occ;

   // Count of valid stages, tracked from the two handshakes rather than re-counting r_vld.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_occ <= '0;
      end else begin
         r_occ <= r_occ + lp_ow'(in_valid & in_ready) - lp_ow'(out_valid & out_ready);
      end
   end

   assign occupancy = r_occ;

`ifndef SYNTHESIS
   a_occ_matches_vld : assert property (@(posedge clk) disable iff (rst)
      r_occ == lp_ow'($countones(r_vld)));
`endif
`endif

endmodule

// File: tb/tb_multi_channel_pipe_reg.sv
// Two instances (depth 2 and depth 3) see identical stimulus; each has its own reference model.
// The model tracks beats in flight as a queue stamped with their acceptance edge.
module tb_multi_channel_pipe_reg;

   localparam logic [23:0] RST_PAT = 24'h00FF00;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [23:0] in_data;
   logic        out_ready;

   logic        in_ready_w  [2];
   logic        out_valid_w [2];
   logic [23:0] out_data_w  [2];
`ifdef PIPE_OCCUPANCY_CNT_EN
   logic [1:0]  occ_w       [2];
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int lane, input logic [23:0] act, input logic [23:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s depth%0d: actual %h required %h", name, lane + 2, act, exp);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int D = g + 2;

      multi_channel_pipe_reg #(
         .p_width(8), .p_channels(3), .p_depth(D), .p_rst_ones_mask(3'b010)
      ) u_dut (
         .clk(clk), .rst(rst), .flush(flush),
         .in_valid(in_valid), .in_ready(in_ready_w[g]), .in_data(in_data),
         .out_valid(out_valid_w[g]), .out_ready(out_ready), .out_data(out_data_w[g])
`ifdef PIPE_OCCUPANCY_CNT_EN
         , .occupancy(occ_w[g])
`endif
      );

      logic [23:0] q_dat [$];
      int          q_edge [$];
      int          n_edge  = 0;
      logic [23:0] last    = '0;
      bit          started = 1'b0;

      // Predict this cycle's outputs, compare, then apply what the next rising edge will do.
      always @(negedge clk) begin
         logic exp_rdy;
         logic exp_ov;
         if (!started) begin
            if (rst) begin
               started = 1'b1;
               last    = RST_PAT;
            end
         end else begin
            exp_rdy = (q_dat.size() < D) || out_ready;
            exp_ov  = (q_dat.size() > 0) && ((n_edge - q_edge[0]) >= D - 1);
            chk("in_ready", g, 24'(in_ready_w[g]), 24'(exp_rdy));
            chk("out_valid", g, 24'(out_valid_w[g]), 24'(exp_ov));
            if (out_valid_w[g] === 1'b1) begin
               if (q_dat.size() == 0) chk("spurious_out", g, 24'(out_valid_w[g]), 24'd0);
               else chk("out_data", g, out_data_w[g], q_dat[0]);
            end else begin
               chk("idle_data", g, out_data_w[g], last);
            end
`ifdef PIPE_OCCUPANCY_CNT_EN
            chk("occupancy", g, 24'(occ_w[g]), 24'(q_dat.size()));
`endif
            if (exp_ov) last = q_dat[0];
            if (rst) begin
               q_dat.delete();
               q_edge.delete();
               last = RST_PAT;
            end else if (flush) begin
               q_dat.delete();
               q_edge.delete();
            end else begin
               if (exp_ov && out_ready) begin
                  void'(q_dat.pop_front());
                  void'(q_edge.pop_front());
               end
               if (in_valid && exp_rdy) begin
                  q_dat.push_back(in_data);
                  q_edge.push_back(n_edge + 1);
               end
            end
            n_edge++;
         end
      end
   end

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic beat(input logic [23:0] d);
      in_valid = 1'b1;
      in_data  = d;
      cyc();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(2);

      // Streaming at full rate.
      out_ready = 1'b1;
      beat(24'h010203);
      beat(24'h040506);
      in_valid = 1'b0;
      cyc(4);

      // Backpressure fill, then release while the third beat is still offered.
      out_ready = 1'b0;
      beat(24'h0A0A0A);
      beat(24'h0B0B0B);
      beat(24'h0C0C0C);
      cyc(2);
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc(5);

      // Bubble collapse: one beat, then keep offering under stall.
      beat(24'h111111);
      out_ready = 1'b0;
      beat(24'h222222);
      beat(24'h333333);
      beat(24'h444444);
      beat(24'h555555);
      in_valid = 1'b0;
      out_ready = 1'b1;
      cyc(5);

      // Flush with beats stored and an input offered.
      out_ready = 1'b0;
      beat(24'h666666);
      beat(24'h777777);
      in_data = 24'hDEADBE;
      flush   = 1'b1;
      cyc();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cyc(5);

      // Reset while the pipeline is full and stalled.
      out_ready = 1'b0;
      beat(24'h888888);
      beat(24'h999999);
      beat(24'hAAAAAA);
      in_valid = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0; out_ready = 1'b1;
      cyc(5);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 24'($urandom);
         out_ready = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         flush     = ($urandom_range(0, 40) == 0);
         rst       = ($urandom_range(0, 150) == 0);
         cyc();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cyc(6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
